// File: rtl/uart_console_pkg.sv
// rtl/uart_console_pkg.sv - shared types and helpers for the UART console receiver
package uart_console_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_t;

  typedef enum logic [1:0] {
    H_IDLE,
    H_VALID,
    H_ACKED
  } hs_state_t;

  function automatic int cnt_width(input int clks_per_bit);
    return (clks_per_bit < 2) ? 1 : $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/console_byte_fifo.sv
// rtl/console_byte_fifo.sv - synchronous byte FIFO between receiver and handshake
module console_byte_fifo
  import uart_console_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] push_data,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] head_data,
  output logic                 empty,
  output logic                 full
);

  localparam int AW = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_rd_ptr;
  logic [AW-1:0]        r_wr_ptr;
  logic [AW:0]          r_count;
  logic                 w_pop;
  logic                 w_push;

  // A pop in the same cycle frees a slot, so a full FIFO may still accept the push.
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  assign head_data = r_mem[r_rd_ptr];
  assign empty     = (r_count == '0);
  assign full      = (r_count == (AW+1)'(FIFO_DEPTH));

endmodule

// File: rtl/uart_console_rx.sv
// rtl/uart_console_rx.sv - 8N1 UART receiver feeding CONSOLE_IN through a FIFO and valid/ack handshake
module uart_console_rx
  import uart_console_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       RX,
  output logic [7:0] CONSOLE_IN,
  output logic       CONSOLE_IN_valid,
  input  logic       CONSOLE_IN_ack,
  output logic       FRAME_ERR,
  output logic       OVERRUN
);

  localparam int                 CNT_W    = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]   HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]   FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam int                 BIT_W    = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0]   LAST_BIT = BIT_W'(DATA_BITS - 1);

  logic [1:0]           r_sync;
  rx_state_t            r_rx_state;
  logic [CNT_W-1:0]     r_baud_cnt;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_frame_err;
  logic                 r_overrun;
  hs_state_t            r_hs_state;
  logic [7:0]           r_console_in;
  logic                 r_valid;

  logic                 w_rx;
  logic                 w_stop_sample;
  logic                 w_push;
  logic                 w_drop;
  logic                 w_pop;
  logic [DATA_BITS-1:0] w_head;
  logic                 w_empty;
  logic                 w_full;

  assign w_rx          = r_sync[1];
  assign w_stop_sample = (r_rx_state == RX_STOP) && (r_baud_cnt == FULL_M1);
  assign w_pop         = (r_hs_state == H_ACKED) && !CONSOLE_IN_ack;
  assign w_push        = w_stop_sample && w_rx && (!w_full || w_pop);
  assign w_drop        = w_stop_sample && w_rx && w_full && !w_pop;

  always_ff @(posedge CLK) begin
    if (!RESET_N) r_sync <= 2'b11;
    else          r_sync <= {r_sync[0], RX};
  end

  // Baud counter restarts on every sample so each later sample lands mid-bit.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_rx_state  <= RX_IDLE;
      r_baud_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (!w_rx) begin
            r_rx_state <= RX_START;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
          end
        end
        RX_START: begin
          if (r_baud_cnt == HALF_M1) begin
            r_baud_cnt <= '0;
            r_rx_state <= w_rx ? RX_IDLE : RX_DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_baud_cnt == FULL_M1) begin
            r_baud_cnt <= '0;
            r_shift    <= {w_rx, r_shift[DATA_BITS-1:1]};
            if (r_bit_cnt == LAST_BIT) r_rx_state <= RX_STOP;
            else                       r_bit_cnt  <= r_bit_cnt + 1'b1;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_baud_cnt == FULL_M1) begin
            r_baud_cnt <= '0;
            if (w_rx) begin
              r_overrun  <= w_drop;
              r_rx_state <= RX_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_rx_state  <= RX_WAIT_IDLE;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        RX_WAIT_IDLE: begin
          if (w_rx) r_rx_state <= RX_IDLE;
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  console_byte_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .push      (w_push),
    .push_data (r_shift),
    .pop       (w_pop),
    .head_data (w_head),
    .empty     (w_empty),
    .full      (w_full)
  );

  // The head stays in the FIFO until the ack falls, so CONSOLE_IN holds a registered copy.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_hs_state   <= H_IDLE;
      r_console_in <= 8'h00;
      r_valid      <= 1'b0;
    end else begin
      case (r_hs_state)
        H_IDLE: begin
          if (!w_empty) begin
            r_console_in <= w_head;
            r_valid      <= 1'b1;
            r_hs_state   <= H_VALID;
          end
        end
        H_VALID: begin
          if (CONSOLE_IN_ack) r_hs_state <= H_ACKED;
        end
        H_ACKED: begin
          if (!CONSOLE_IN_ack) begin
            r_valid    <= 1'b0;
            r_hs_state <= H_IDLE;
          end
        end
        default: r_hs_state <= H_IDLE;
      endcase
    end
  end

  assign CONSOLE_IN       = r_console_in;
  assign CONSOLE_IN_valid = r_valid;
  assign FRAME_ERR        = r_frame_err;
  assign OVERRUN          = r_overrun;

endmodule
